// File: rtl/scan_chain_seq.sv
// Multi-chain scan wrapper with autonomous shift/capture sequencer; one pattern per START, period CHAIN_LEN+2.
// Define SCAN_MISR_EN to compact the shifted-out response stream into SIG; otherwise SIG is tied to 0.
module scan_chain_seq #(
    parameter int                CHAIN_LEN  = 4,
    parameter int                NUM_CHAINS = 1,
    parameter int                CNT_W      = 8,
    parameter int                MISR_W     = 16,
    parameter logic [MISR_W-1:0] MISR_POLY  = 16'h1021
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             START,
    input  logic [NUM_CHAINS-1:0]            SI,
    output logic [NUM_CHAINS-1:0]            SO,
    output logic                             SE,
    output logic                             BUSY,
    output logic                             DONE,
    output logic [CNT_W-1:0]                 PAT_CNT,
    output logic [NUM_CHAINS*CHAIN_LEN-1:0]  FUNC_Q,
    input  logic [NUM_CHAINS*CHAIN_LEN-1:0]  FUNC_D,
    output logic [MISR_W-1:0]                SIG
);
    localparam int SC_W = $clog2(CHAIN_LEN + 1);
    localparam int TOT  = NUM_CHAINS * CHAIN_LEN;
    localparam logic [SC_W-1:0] LAST_SHIFT = SC_W'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CAPTURE} state_t;

    state_t                r_state;
    logic [SC_W-1:0]       r_shift_cnt;
    logic [TOT-1:0]        r_chain;
    logic [CNT_W-1:0]      r_pat_cnt;
    logic                  r_done;
    logic [NUM_CHAINS-1:0] w_so;
    logic [TOT-1:0]        w_shifted;

    always_comb begin
        w_so      = '0;
        w_shifted = '0;
        for (int c = 0; c < NUM_CHAINS; c++) begin
            w_so[c] = r_chain[c*CHAIN_LEN + CHAIN_LEN - 1];
            w_shifted[c*CHAIN_LEN +: CHAIN_LEN] = {r_chain[c*CHAIN_LEN +: CHAIN_LEN-1], SI[c]};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_shift_cnt <= '0;
            r_chain     <= '0;
            r_pat_cnt   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_state     <= S_SHIFT;
                        r_shift_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    r_chain     <= w_shifted;
                    r_shift_cnt <= r_shift_cnt + SC_W'(1);
                    if (r_shift_cnt == LAST_SHIFT)
                        r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_chain <= FUNC_D;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                    if (r_pat_cnt != '1)
                        r_pat_cnt <= r_pat_cnt + CNT_W'(1);
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SCAN_MISR_EN
    logic [MISR_W-1:0] r_sig;

    // Compacts exactly the bits leaving the chains, one step per shift edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_sig <= '0;
        else if (r_state == S_SHIFT)
            r_sig <= {r_sig[MISR_W-2:0], 1'b0}
                   ^ (r_sig[MISR_W-1] ? MISR_POLY : '0)
                   ^ MISR_W'(w_so);
    end

    assign SIG = r_sig;
`else
    assign SIG = '0;
`endif

    assign SO      = w_so;
    assign SE      = (r_state == S_SHIFT);
    assign BUSY    = (r_state != S_IDLE);
    assign DONE    = r_done;
    assign PAT_CNT = r_pat_cnt;
    assign FUNC_Q  = r_chain;

endmodule

// File: tb/tb_scan_chain_seq.sv
// Scoreboard bench for scan_chain_seq: default instance (L=4, 1 chain) and a 2-chain, L=3, CNT_W=2 instance.
module tb_scan_chain_seq;
    localparam logic [15:0] POLY = 16'h1021;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;

    logic        a_start = 1'b0, a_si = 1'b0, a_so, a_se, a_busy, a_done;
    logic [7:0]  a_pat;
    logic [3:0]  a_fq, a_fd = 4'h0;
    logic [15:0] a_sig;

    logic        b_start = 1'b0, b_se, b_busy, b_done;
    logic [1:0]  b_si = 2'b00, b_so, b_pat;
    logic [5:0]  b_fq, b_fd = 6'h0;
    logic [15:0] b_sig;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [31:0] sb_q[$];
    logic [3:0]  m_a     = 4'h0;
    logic [15:0] m_sig_a = 16'h0;
    int          m_pa    = 0;
    logic [5:0]  m_b     = 6'h0;
    logic [15:0] m_sig_b = 16'h0;
    int          m_pb    = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    scan_chain_seq u_a (
        .CLK(CLK), .RST(RST), .START(a_start), .SI(a_si), .SO(a_so), .SE(a_se),
        .BUSY(a_busy), .DONE(a_done), .PAT_CNT(a_pat), .FUNC_Q(a_fq), .FUNC_D(a_fd), .SIG(a_sig)
    );

    scan_chain_seq #(.CHAIN_LEN(3), .NUM_CHAINS(2), .CNT_W(2)) u_b (
        .CLK(CLK), .RST(RST), .START(b_start), .SI(b_si), .SO(b_so), .SE(b_se),
        .BUSY(b_busy), .DONE(b_done), .PAT_CNT(b_pat), .FUNC_Q(b_fq), .FUNC_D(b_fd), .SIG(b_sig)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic sb_pop_chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxx_xxxx;
        chk(tag, obs, e);
    endtask

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? POLY : 16'h0) ^ d;
    endfunction

    // si_seq[3] is shifted first and ends up in the chain MSB.
    task automatic pat_a(input logic [3:0] si_seq, input logic [3:0] fd, input bit glitch);
        @(negedge CLK);
        a_start = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            sb_q.push_back(32'(m_a[i]));
`ifdef SCAN_MISR_EN
            m_sig_a = misr(m_sig_a, {15'h0, m_a[i]});
`endif
        end
        sb_q.push_back(32'(si_seq));
        sb_q.push_back(32'(fd));
        sb_q.push_back(32'(m_sig_a));
        m_a  = fd;
        m_pa = (m_pa == 255) ? 255 : m_pa + 1;
        @(negedge CLK);
        a_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("a_se_shift", a_se, 1);
            chk("a_busy_shift", a_busy, 1);
            sb_pop_chk("a_so", a_so);
            a_si    = si_seq[3-i];
            a_start = glitch && (i == 1);
            @(negedge CLK);
        end
        a_start = 1'b0;
        chk("a_se_capture", a_se, 0);
        chk("a_busy_capture", a_busy, 1);
        sb_pop_chk("a_fq_capture", a_fq);
        a_fd = fd;
        @(negedge CLK);
        chk("a_done", a_done, 1);
        chk("a_busy_done", a_busy, 0);
        sb_pop_chk("a_fq_resp", a_fq);
        sb_pop_chk("a_sig", a_sig);
        chk("a_pat_cnt", a_pat, m_pa);
        @(negedge CLK);
        chk("a_done_pulse", a_done, 0);
    endtask

    // Three SI words, first word in si_seq[5:4]; bit c of each word feeds chain c.
    task automatic pat_b(input logic [5:0] si_seq, input logic [5:0] fd);
        logic [5:0] nb;
        logic [1:0] so;
        @(negedge CLK);
        b_start = 1'b1;
        for (int i = 2; i >= 0; i--) begin
            so = {m_b[3+i], m_b[i]};
            sb_q.push_back(32'(so));
`ifdef SCAN_MISR_EN
            m_sig_b = misr(m_sig_b, {14'h0, so});
`endif
        end
        nb = '0;
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < 2; c++)
                nb[c*3 + 2 - k] = si_seq[4 - 2*k + c];
        sb_q.push_back(32'(nb));
        sb_q.push_back(32'(m_sig_b));
        m_b  = fd;
        m_pb = (m_pb >= 3) ? 3 : m_pb + 1;
        @(negedge CLK);
        b_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("b_se_shift", b_se, 1);
            sb_pop_chk("b_so", b_so);
            b_si = si_seq[4-2*i +: 2];
            @(negedge CLK);
        end
        chk("b_se_capture", b_se, 0);
        sb_pop_chk("b_fq_capture", b_fq);
        b_fd = fd;
        @(negedge CLK);
        chk("b_done", b_done, 1);
        chk("b_fq_resp", b_fq, fd);
        sb_pop_chk("b_sig", b_sig);
        chk("b_pat_cnt", b_pat, m_pb);
    endtask

    task automatic wait_done_a(output int t);
        int k = 0;
        while (!a_done && k < 20) begin
            @(negedge CLK);
            k++;
        end
        chk("a_done_seen", a_done, 1);
        t = cyc;
    endtask

    initial begin
        int t1, t2;
        #3 RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("a_reset", {a_so, a_se, a_busy, a_done, a_pat, a_fq, a_sig}, 0);
        chk("b_reset", {b_so, b_se, b_busy, b_done, b_pat, b_fq, b_sig}, 0);
        RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("a_idle_hold", {a_so, a_se, a_busy, a_done, a_pat, a_fq, a_sig}, 0);
        end

        pat_a(4'b1011, 4'b0110, 1'b0);
        chk("a_fq_1011", a_fq, 4'b0110);
        pat_a(4'b0101, 4'b1001, 1'b1);
`ifdef SCAN_MISR_EN
        chk("a_sig_ref", a_sig, 16'h0006);
`else
        chk("a_sig_ref", a_sig, 16'h0000);
`endif
        for (int i = 0; i < 3; i++)
            pat_a(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);

        pat_b(6'b01_10_11, 6'b110_001);
        chk("b_fq_ref", m_b, 6'b110_001);
        for (int i = 0; i < 4; i++)
            pat_b(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        chk("b_pat_sat", b_pat, 2'd3);

        // START held high: patterns run back-to-back every L+2 cycles.
        @(negedge CLK);
        a_si    = 1'b0;
        a_start = 1'b1;
        wait_done_a(t1);
        @(negedge CLK);
        wait_done_a(t2);
        chk("a_b2b_period", t2 - t1, 6);
        a_start = 1'b0;
        @(negedge CLK);
        chk("a_b2b_stop", a_busy, 0);

        // Reset in the second shift cycle.
        a_start = 1'b1;
        @(negedge CLK);
        a_start = 1'b0;
        a_si    = 1'b1;
        @(negedge CLK);
        chk("a_mid_shift_se", a_se, 1);
        RST = 1'b1;
        #1;
        chk("a_rst_mid", {a_so, a_se, a_busy, a_done, a_pat, a_fq, a_sig}, 0);
        @(negedge CLK);
        RST = 1'b0;
        m_a = 4'h0; m_sig_a = 16'h0; m_pa = 0;
        sb_q.delete();
        repeat (3) @(negedge CLK);
        chk("a_rst_idle", {a_se, a_busy, a_fq}, 0);
        pat_a(4'b1100, 4'b0011, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/scan_chain_seq.md
# scan_chain_seq

Parametrised multi-chain scan wrapper with a built-in shift/capture sequencer. Holds `NUM_CHAINS` scan chains of `CHAIN_LEN` flops that drive and capture a combinational circuit-under-test, and autonomously runs one pattern per `START`: shift-in (overlapped with previous response shift-out), then single capture. It supersedes the hand-driven single-chain scan test circuit in the serial-scanning exercises; tester logic only supplies serial data and `START`.

## Interface
Parameters:
- `CHAIN_LEN`, 4: flops per chain; must be ≥ 2.
- `NUM_CHAINS`, 1: parallel chains; must be ≤ `MISR_W`.
- `CNT_W`, 8: width of the pattern counter.
- `MISR_W`, 16: signature width.
- `MISR_POLY`, 16'h1021: MISR feedback polynomial, `MISR_W` bits.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `START`  in  1  request one pattern; sampled only in IDLE.
- `SI`  in  `NUM_CHAINS`  serial data, bit c feeds chain c.
- `SO`  out  `NUM_CHAINS`  serial out; `SO[c]` = Q[c][CHAIN_LEN-1].
- `SE`  out  1  scan enable; decoded from the state register.
- `BUSY`  out  1  high in SHIFT and CAPTURE.
- `DONE`  out  1  one-cycle pulse after each capture.
- `PAT_CNT`  out  `CNT_W`  completed patterns; saturating.
- `FUNC_Q`  out  `NUM_CHAINS*CHAIN_LEN`  chain contents to the CUT; chain c occupies `[c*CHAIN_LEN +: CHAIN_LEN]`.
- `FUNC_D`  in  `NUM_CHAINS*CHAIN_LEN`  CUT responses, same packing.
- `SIG`  out  `MISR_W`  MISR signature.

## Operation
- States: IDLE, SHIFT, CAPTURE. Shift counter width is clog2(`CHAIN_LEN`+1).
- IDLE: chains hold. If `START`=1, go to SHIFT and clear the counter. In any other state `START` is ignored.
- SHIFT: `SE`=1. Each edge updates every chain as Q[c] <= {Q[c][CHAIN_LEN-2:0], SI[c]}. The first SI bit ends at Q[c][CHAIN_LEN-1]. After exactly `CHAIN_LEN` shift edges, go to CAPTURE.
- CAPTURE: `SE`=0. One edge loads Q <= `FUNC_D`, increments `PAT_CNT` (holds at all-ones), and returns to IDLE. `DONE` is registered high for the following cycle.
- The response stays in the chains. The next `START` shifts it out on `SO`, MSB (Q[CHAIN_LEN-1]) first, while the new pattern shifts in. The final response is flushed with an extra `START` using don't-care `SI`.
- Reset (any time, including mid-SHIFT): state IDLE, all chain flops 0, counters 0, `SE`=0, `BUSY`=0, `DONE`=0, `PAT_CNT`=0, `SIG`=0, `FUNC_Q`=0, `SO`=0. Operation resumes only on a new `START`.

## Timing
- Cycle 0: `START` is sampled at the edge.
- Cycles 1..L (L=`CHAIN_LEN`): SHIFT. `SI` must be stable before each edge. `SO` is valid during the same cycle and shows the bit leaving on that edge.
- Cycle L+1: CAPTURE. `FUNC_D` is sampled at its closing edge.
- Cycle L+2: IDLE with `DONE`=1. A `START` held high here is accepted, so patterns run back-to-back with a period of L+2 cycles.
- `BUSY` is high for cycles 1..L+1. `SE` is high for cycles 1..L.

## Configuration
- `SCAN_MISR_EN` defined: on every SHIFT edge, `SIG` <= (`SIG`<<1) ^ (`SIG`[MISR_W-1] ? `MISR_POLY` : 0) ^ zero-extended `SO`. `SIG` holds in all other states and is cleared only by `RST`.
- `SCAN_MISR_EN` undefined: no MISR logic; `SIG` is tied to 0. The port list is unchanged.

## Test plan
Defaults apply unless stated (L=4, one chain).
- Reset: assert `RST` → all outputs 0. Release and hold for 10 cycles without `START` → outputs unchanged.
- Single load: `START`, then `SI` 1,0,1,1 over cycles 1–4 → `FUNC_Q`=4'b1011 in cycle 5, `SE` high in cycles 1–4 only, `DONE` high in cycle 6, `PAT_CNT`=1.
- Capture/unload: drive `FUNC_D`=4'b0110 in the capture cycle, then issue a second `START` → `SO` reads 0,1,1,0 in the next four shift cycles; `PAT_CNT`=2.
- Protocol: hold `START`=1 continuously → patterns repeat every 6 cycles. Pulse `START` during SHIFT → ignored and no length change. Assert `RST` in the 2nd shift cycle → IDLE with chains 0.
- Multi-chain (NUM_CHAINS=2, L=3): `SI`=2'b01,2'b10,2'b11 → `FUNC_Q`=6'b011_101 (chain 1 = 011, chain 0 = 101).
- `SCAN_MISR_EN`: run the load/capture/unload sequence above (responses 0,1,1,0) → `SIG`=16'h0006. Without the macro → `SIG`=0. With `CNT_W`=2, run 5 patterns → `PAT_CNT`=3.
